ifm_read_scheduler: RTL and testbench
=====================================

# ifm_read_scheduler

Read-side sequencer for the 12-bank IFM BRAM array filled by the RDMA2 write path. It watches the per-bank full flags, picks which bank, or which group of three banks, feeds the PE array next, and drives the per-bank `dout_valid` read strobes under PE backpressure. It reports start, busy and done to the layer controller. It sits between the IFM BRAM controllers and the convolution PE array, and is active only for conv 1x1 and conv 3x3 layers.

## Interface
- No parameters; bank count 12, beat width 64 bit, 8 channels per beat are package constants
- `clk` in 1 — system clock
- `rst` in 1 — asynchronous, active-high reset
- `start` in 1 — layer start pulse; ignored while `busy`
- `is_conv_1` in 1 — 1x1 layer: one bank per row
- `is_conv_3` in 1 — 3x3 layer: three banks (rows) read together
- `ifm_width` in 9 — IFM width in pixels
- `ifm_channel` in 11 — IFM channels, must be a multiple of 8
- `row_count` in 9 — number of reads to schedule: banks for conv1, sets for conv3
- `ifm_bram_full` in 12 — packed full flags; bank b sits at bit (b%3)*4 + b/3
- `pe_ready` in 1 — PE array accepts a beat this cycle
- `dout_valid` out 12 — per-bank read strobe, indexed by bank number (not packed)
- `pe_beat_valid` out 1 — read data valid at the PE input
- `pe_bank_mask` out 12 — banks whose data accompanies `pe_beat_valid`
- `busy` out 1 — layer in progress
- `done` out 1 — one-cycle pulse when the layer completes
- `cfg_err` out 1 — one-cycle pulse when `start` arrives with an illegal configuration

## Operation
- Reads per bank: BEATS = `ifm_width` * (`ifm_channel` >> 3). Computed as a 17-bit product, latched at `start`.
- Bank sets: set k = banks {3k, 3k+1, 3k+2}, k = 0..3.
- Illegal configuration:
  - both or neither of `is_conv_1` / `is_conv_3` set; `ifm_channel[2:0]` ≠ 0; `ifm_width` = 0; `row_count` = 0.
  - Response: `cfg_err` pulses and the FSM stays in IDLE.
- FSM states and transitions:
  - IDLE → WAIT on a legal `start`. Bank pointer and set pointer reset to 0; row counter and beat counter cleared.
  - WAIT: conv1 needs the full flag of bank `ptr`; conv3 needs all three flags of set `set`. When satisfied → READ.
  - READ: `dout_valid` is asserted on the selected bank(s) whenever `pe_ready` = 1. The beat counter increments per strobe. On the strobe with counter = BEATS-1 → GAP.
  - GAP: held exactly 2 cycles so the BRAM controller can drop its full flag. Row counter increments. If row counter = `row_count` → FIN. Otherwise the pointer advances (conv1: ptr 11 → 0; conv3: set 3 → 0) and the FSM goes to WAIT.
  - FIN: `done` = 1 for one cycle → IDLE.
- `busy` = 1 in every state except IDLE.
- A changed `is_conv_*` or `ifm_*` input mid-layer has no effect; latched values are used.
- `start` while busy is ignored, with no error.

## Timing
- Reset values: all outputs 0; FSM in IDLE; all counters and pointers 0.
- `dout_valid` is combinational: (state = READ) & `pe_ready` & bank-select. Strobes appear in the same cycle as `pe_ready`.
- BRAM read latency is 1 cycle. `pe_beat_valid` and `pe_bank_mask` are registered copies of (|`dout_valid`) and `dout_valid`.
- Gaps in `pe_ready` stall READ with no loss and no duplicate strobe.
- From `start` to first strobe: 2 cycles minimum (IDLE→WAIT, WAIT→READ), when the flags are already full.
- `done` comes 3 cycles after the last strobe (2 GAP cycles + FIN).
- Full flags are sampled only in WAIT. A flag that drops during READ does not abort the read.
- `rst` mid-layer: asynchronous return to IDLE; outputs are 0 immediately, with no `done`.

## Configuration
- `IFM_SCHED_PERF_EN` defined adds two 32-bit outputs:
  - `stall_cnt`: cycles in READ with `pe_ready` = 0.
  - `starve_cnt`: cycles in WAIT.
- Both counters clear on a legal `start`, saturate at all-ones, and reset to 0.
- Without the macro, the ports and counters do not exist and behaviour is otherwise identical.

## Structure
- Shared package `ifm_sched_pkg`:
  - constants NUM_BANKS=12, BANKS_PER_SET=3, NUM_SETS=4, CH_PER_BEAT=8, GAP_CYCLES=2
  - state enum {IDLE, WAIT, READ, GAP, FIN}
  - function mapping bank index to packed full-flag bit
- One natural sub-module, `ifm_full_unpack`: combinational reorder of the packed `ifm_bram_full` into bank order, reused by the RDMA2 side.

## Test plan
- conv1, width 4, channel 16, `row_count` 2, banks 0-1 full, `pe_ready`=1:
  - 8 strobes on bank 0, then 8 on bank 1, with a 2-cycle gap between them.
  - `done` 3 cycles after the last strobe.
- conv3, width 2, channel 8, `row_count` 5, all banks pre-full:
  - sets 0,1,2,3,0 each get 2 strobes on masks 0x007, 0x038, 0x1C0, 0xE00, 0x007.
- Backpressure: `pe_ready` toggles every cycle during READ:
  - exactly BEATS strobes total.
  - `pe_beat_valid` lags each strobe by 1 cycle.
  - `stall_cnt` = BEATS-1 with `IFM_SCHED_PERF_EN`.
- Starvation: conv3 where bank 2 full arrives 10 cycles after banks 0-1:
  - no strobe until 1 cycle after bank 2 full.
  - `starve_cnt` = 10.
- Illegal configuration: `ifm_channel` = 12, or both conv flags set, then `start`:
  - `cfg_err` pulse; `busy` stays 0; no strobes.
- `rst` asserted mid-READ:
  - `dout_valid` drops to 0 in the same cycle.
  - a following `start` restarts at bank 0 with the beat counter at 0.

Source files
------------

// File: rtl/ifm_sched_pkg.sv
// Shared constants, FSM state type and the packed-flag bit mapping for the
// IFM read scheduler and the RDMA2 write side.
package ifm_sched_pkg;

   localparam int NUM_BANKS     = 12;
   localparam int BANKS_PER_SET = 3;
   localparam int NUM_SETS      = 4;
   localparam int CH_PER_BEAT   = 8;
   localparam int GAP_CYCLES    = 2;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WAIT = 3'd1,
      READ = 3'd2,
      GAP  = 3'd3,
      FIN  = 3'd4
   } state_t;

   // Bank b lives at bit (b % 3) * 4 + b / 3 of the packed full-flag vector.
   function automatic int unsigned full_bit(input int unsigned bank);
      return (bank % BANKS_PER_SET) * NUM_SETS + bank / BANKS_PER_SET;
   endfunction

endpackage

// File: rtl/ifm_read_scheduler_if.sv
// Bus between the layer controller / BRAM / PE array and the read scheduler.
// Optional perf counters appear when IFM_SCHED_PERF_EN is defined.
//
// Handshake: a beat moves from BRAM to the PE array in every cycle where the
// scheduler is reading and pe_ready is 1; dout_valid marks exactly those
// cycles, so a strobe is never issued without pe_ready and never repeated.
interface ifm_read_scheduler_if;
   import ifm_sched_pkg::*;

   logic                 start;
   logic                 is_conv_1;
   logic                 is_conv_3;
   logic [8:0]           ifm_width;
   logic [10:0]          ifm_channel;
   logic [8:0]           row_count;
   logic [NUM_BANKS-1:0] ifm_bram_full;
   logic                 pe_ready;
   logic [NUM_BANKS-1:0] dout_valid;
   logic                 pe_beat_valid;
   logic [NUM_BANKS-1:0] pe_bank_mask;
   logic                 busy;
   logic                 done;
   logic                 cfg_err;
   state_t               state_dbg;
`ifdef IFM_SCHED_PERF_EN
   logic [31:0]          stall_cnt;
   logic [31:0]          starve_cnt;

   modport master (
      output start, is_conv_1, is_conv_3, ifm_width, ifm_channel, row_count,
             ifm_bram_full, pe_ready,
      input  dout_valid, pe_beat_valid, pe_bank_mask, busy, done, cfg_err,
             state_dbg, stall_cnt, starve_cnt
   );
   modport slave (
      input  start, is_conv_1, is_conv_3, ifm_width, ifm_channel, row_count,
             ifm_bram_full, pe_ready,
      output dout_valid, pe_beat_valid, pe_bank_mask, busy, done, cfg_err,
             state_dbg, stall_cnt, starve_cnt
   );
`else
   modport master (
      output start, is_conv_1, is_conv_3, ifm_width, ifm_channel, row_count,
             ifm_bram_full, pe_ready,
      input  dout_valid, pe_beat_valid, pe_bank_mask, busy, done, cfg_err,
             state_dbg
   );
   modport slave (
      input  start, is_conv_1, is_conv_3, ifm_width, ifm_channel, row_count,
             ifm_bram_full, pe_ready,
      output dout_valid, pe_beat_valid, pe_bank_mask, busy, done, cfg_err,
             state_dbg
   );
`endif
endinterface

// File: rtl/ifm_read_scheduler_full_unpack.sv
// Reorders the packed IFM BRAM full flags into bank-number order.
module ifm_full_unpack
   import ifm_sched_pkg::*;
(
   input  logic [NUM_BANKS-1:0] full_packed,
   output logic [NUM_BANKS-1:0] full_bank
);

   // Pure wiring: one packed bit per bank.
   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      assign full_bank[b] = full_packed[full_bit(b)];
   end

endmodule

// File: rtl/ifm_read_scheduler.sv
// IFM read scheduler: waits for bank (conv1) or bank-set (conv3) full flags,
// streams BEATS read strobes under PE backpressure, then a fixed gap.
// Define IFM_SCHED_PERF_EN to add stall_cnt / starve_cnt counters.
module ifm_read_scheduler
   import ifm_sched_pkg::*;
(
   input logic                  clk,
   input logic                  rst,
   ifm_read_scheduler_if.slave  bus
);

   localparam logic [0:0] GAP_LAST = 1'(GAP_CYCLES - 1);

   state_t               state_q, state_d;
   logic [3:0]           ptr_q, ptr_d;
   logic [1:0]           set_q, set_d;
   logic [8:0]           row_q, row_d;
   logic [16:0]          beat_q, beat_d;
   logic [0:0]           gap_q, gap_d;
   logic [16:0]          beats_q, beats_d;
   logic [8:0]           rows_q, rows_d;
   logic                 conv3_q, conv3_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 cfg_err_q, cfg_err_d;
   logic                 pbv_q, pbv_d;
   logic [NUM_BANKS-1:0] mask_q, mask_d;
`ifdef IFM_SCHED_PERF_EN
   logic [31:0]          stall_q, stall_d;
   logic [31:0]          starve_q, starve_d;
`endif

   logic [NUM_BANKS-1:0] full_bank;
   logic [NUM_BANKS-1:0] sel;
   logic                 illegal;
   logic                 legal_start;

   ifm_full_unpack u_unpack (
      .full_packed (bus.ifm_bram_full),
      .full_bank   (full_bank)
   );

   // Bank(s) currently owned by the pointer: one bank for conv1, a set for conv3.
   always_comb begin
      sel = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         sel[b] = conv3_q ? (set_q == 2'(b / BANKS_PER_SET)) : (ptr_q == 4'(b));
      end
   end

   assign illegal = (bus.is_conv_1 == bus.is_conv_3) || (bus.ifm_channel[2:0] != 3'd0) ||
                    (bus.ifm_width == 9'd0) || (bus.row_count == 9'd0);
   assign legal_start = (state_q == IDLE) && bus.start && !illegal;

   // Strobes are combinational so the BRAM sees them in the pe_ready cycle.
   assign bus.dout_valid = ((state_q == READ) && bus.pe_ready) ? sel : '0;

   // Next-state logic for the sequencer, counters and registered outputs.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      set_d     = set_q;
      row_d     = row_q;
      beat_d    = beat_q;
      gap_d     = gap_q;
      beats_d   = beats_q;
      rows_d    = rows_q;
      conv3_d   = conv3_q;
      cfg_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (illegal) begin
                  cfg_err_d = 1'b1;
               end else begin
                  state_d = WAIT;
                  ptr_d   = '0;
                  set_d   = '0;
                  row_d   = '0;
                  beat_d  = '0;
                  gap_d   = '0;
                  beats_d = 17'(bus.ifm_width) * 17'(bus.ifm_channel[10:3]);
                  rows_d  = bus.row_count;
                  conv3_d = bus.is_conv_3;
               end
            end
         end
         WAIT: begin
            if ((full_bank & sel) == sel) state_d = READ;
         end
         READ: begin
            if (bus.pe_ready) begin
               if (beat_q == beats_q - 17'd1) begin
                  beat_d  = '0;
                  row_d   = row_q + 9'd1;
                  gap_d   = '0;
                  state_d = GAP;
               end else begin
                  beat_d = beat_q + 17'd1;
               end
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               if (row_q == rows_q) begin
                  state_d = FIN;
               end else begin
                  ptr_d   = (ptr_q == 4'(NUM_BANKS - 1)) ? '0 : ptr_q + 4'd1;
                  set_d   = set_q + 2'd1;
                  state_d = WAIT;
               end
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == FIN);
      pbv_d  = |bus.dout_valid;
      mask_d = bus.dout_valid;
   end

`ifdef IFM_SCHED_PERF_EN
   // Saturating perf counters, cleared by a legal start.
   always_comb begin
      stall_d  = stall_q;
      starve_d = starve_q;
      if (legal_start) begin
         stall_d  = '0;
         starve_d = '0;
      end else begin
         if ((state_q == READ) && !bus.pe_ready && (stall_q != '1)) stall_d = stall_q + 32'd1;
         if ((state_q == WAIT) && (starve_q != '1)) starve_d = starve_q + 32'd1;
      end
   end
   assign bus.stall_cnt  = stall_q;
   assign bus.starve_cnt = starve_q;
`endif

   // State register; asynchronous reset returns everything to idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         set_q     <= '0;
         row_q     <= '0;
         beat_q    <= '0;
         gap_q     <= '0;
         beats_q   <= '0;
         rows_q    <= '0;
         conv3_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
         pbv_q     <= 1'b0;
         mask_q    <= '0;
`ifdef IFM_SCHED_PERF_EN
         stall_q   <= '0;
         starve_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         set_q     <= set_d;
         row_q     <= row_d;
         beat_q    <= beat_d;
         gap_q     <= gap_d;
         beats_q   <= beats_d;
         rows_q    <= rows_d;
         conv3_q   <= conv3_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         cfg_err_q <= cfg_err_d;
         pbv_q     <= pbv_d;
         mask_q    <= mask_d;
`ifdef IFM_SCHED_PERF_EN
         stall_q   <= stall_d;
         starve_q  <= starve_d;
`endif
      end
   end

   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.cfg_err       = cfg_err_q;
   assign bus.pe_beat_valid = pbv_q;
   assign bus.pe_bank_mask  = mask_q;
   assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_ifm_read_scheduler.sv
// Testbench for ifm_read_scheduler: table of configurations, a randomized
// layer runner checked against a strobe-sequence model, and hand sequences
// for starvation and mid-layer reset. Perf checks under IFM_SCHED_PERF_EN.
module tb_ifm_read_scheduler;
   import ifm_sched_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   ifm_read_scheduler_if bus ();

   ifm_read_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   logic [11:0] exp_q[$];
   int total = 0;
   int bad = 0;
   int strobe_cnt = 0;
   int done_cnt = 0;
   int last_strobe_cyc = 0;
   int first_strobe_cyc = -1;
   bit mon_en = 1'b0;
   logic [11:0] prev_dv = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: row r of a layer reads bank r mod 12 (conv1) or set r mod 4 (conv3).
   function automatic logic [11:0] row_mask(input bit c1, input int r);
      logic [11:0] one;
      logic [11:0] three;
      one   = 12'h001;
      three = 12'h007;
      if (c1) return one << (r % NUM_BANKS);
      return three << (BANKS_PER_SET * (r % NUM_SETS));
   endfunction

   // Monitor at the falling edge: strobe order, 1-cycle data lag, done latency.
   always @(negedge clk) begin
      if (rst) begin
         prev_dv = '0;
      end else if (mon_en) begin
         check("beat_valid_lag", {31'd0, bus.pe_beat_valid}, {31'd0, |prev_dv});
         check("bank_mask_lag", {20'd0, bus.pe_bank_mask}, {20'd0, prev_dv});
         if (bus.dout_valid != '0) begin
            strobe_cnt++;
            last_strobe_cyc = cyc;
            if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_strobe: got %03h expected none (cycle %0d)", bus.dout_valid, cyc);
            end else begin
               check("strobe_mask", {20'd0, bus.dout_valid}, {20'd0, exp_q.pop_front()});
            end
         end
         if (bus.done) begin
            done_cnt++;
            check("done_latency", cyc - last_strobe_cyc, 3);
         end
         prev_dv = bus.dout_valid;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input bit c1, input bit c3, input int w, input int ch, input int rows);
      bus.is_conv_1   = c1;
      bus.is_conv_3   = c3;
      bus.ifm_width   = 9'(w);
      bus.ifm_channel = 11'(ch);
      bus.row_count   = 9'(rows);
   endtask

   // mode 0: pe_ready always 1; 1: toggling, high in the first READ cycle; 2: random.
   task automatic run_layer(input bit c1, input int w, input int ch, input int rows, input int mode);
      int beats;
      int strobes0;
      int done0;
      int start_cyc;
      int budget;
      int n;
      beats    = w * (ch / CH_PER_BEAT);
      budget   = beats * rows * 4 + rows * 8 + 20;
      strobes0 = strobe_cnt;
      done0    = done_cnt;
      for (int r = 0; r < rows; r++)
         for (int b = 0; b < beats; b++) exp_q.push_back(row_mask(c1, r));
      first_strobe_cyc = -1;
      set_cfg(c1, !c1, w, ch, rows);
      bus.pe_ready = 1'b0;
      bus.start = 1'b1;
      start_cyc = cyc;
      step();
      bus.start = 1'b0;
      check("legal_no_cfg_err", {31'd0, bus.cfg_err}, 32'd0);
      check("busy_after_start", {31'd0, bus.busy}, 32'd1);
      // Mid-layer config changes must be ignored.
      set_cfg($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 511),
              $urandom_range(0, 2047), $urandom_range(0, 511));
      n = 0;
      while (done_cnt == done0 && n < budget) begin
         case (mode)
            0:       bus.pe_ready = 1'b1;
            1:       bus.pe_ready = (n % 2 == 1);
            default: begin
               bus.pe_ready = ($urandom_range(0, 3) != 0);
               bus.start    = ($urandom_range(0, 7) == 0);
            end
         endcase
         step();
         n++;
      end
      bus.start = 1'b0;
      bus.pe_ready = 1'b0;
      check("layer_done_seen", done_cnt - done0, 1);
      check("strobe_total", strobe_cnt - strobes0, beats * rows);
      check("exp_q_drained", exp_q.size(), 0);
      check("idle_after_done", {31'd0, bus.busy}, 32'd0);
      if (mode == 0) check("start_to_strobe", first_strobe_cyc - start_cyc, 2);
`ifdef IFM_SCHED_PERF_EN
      check("starve_cnt", bus.starve_cnt, rows);
      if (mode == 0) check("stall_cnt_none", bus.stall_cnt, 0);
      if (mode == 1 && rows == 1) check("stall_cnt_toggle", bus.stall_cnt, beats - 1);
`endif
      exp_q.delete();
      step();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit c1;
      bit c3;
      int w;
      int ch;
      int rows;
      int mode;
      bit err;
   } vec_t;

   vec_t vecs[11];

   initial begin
      int done0;
      int flag_cyc;
      int n;

      vecs[0]  = '{1, 0, 4, 16, 2, 0, 0};
      vecs[1]  = '{0, 1, 2, 8, 5, 0, 0};
      vecs[2]  = '{1, 0, 3, 24, 1, 1, 0};
      vecs[3]  = '{0, 1, 5, 8, 1, 1, 0};
      vecs[4]  = '{1, 0, 4, 12, 2, 0, 1};
      vecs[5]  = '{1, 1, 4, 16, 2, 0, 1};
      vecs[6]  = '{0, 0, 4, 16, 2, 0, 1};
      vecs[7]  = '{1, 0, 0, 16, 2, 0, 1};
      vecs[8]  = '{0, 1, 4, 16, 0, 0, 1};
      vecs[9]  = '{1, 0, 2, 16, 14, 2, 0};
      vecs[10] = '{0, 1, 3, 16, 6, 2, 0};

      bus.start = 1'b0;
      bus.pe_ready = 1'b0;
      bus.ifm_bram_full = '1;
      set_cfg(0, 0, 0, 0, 0);
      repeat (3) step();
      rst = 1'b0;
      step();

      // Reset state
      check("rst_dout_valid", {20'd0, bus.dout_valid}, 32'd0);
      check("rst_beat_valid", {31'd0, bus.pe_beat_valid}, 32'd0);
      check("rst_bank_mask", {20'd0, bus.pe_bank_mask}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_cfg_err", {31'd0, bus.cfg_err}, 32'd0);
`ifdef IFM_SCHED_PERF_EN
      check("rst_stall_cnt", bus.stall_cnt, 0);
      check("rst_starve_cnt", bus.starve_cnt, 0);
`endif
      mon_en = 1'b1;

      // Table-driven configurations
      foreach (vecs[i]) begin
         if (vecs[i].err) begin
            set_cfg(vecs[i].c1, vecs[i].c3, vecs[i].w, vecs[i].ch, vecs[i].rows);
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            check("cfg_err_pulse", {31'd0, bus.cfg_err}, 32'd1);
            check("cfg_err_not_busy", {31'd0, bus.busy}, 32'd0);
            step();
            check("cfg_err_cleared", {31'd0, bus.cfg_err}, 32'd0);
            check("cfg_err_still_idle", {31'd0, bus.busy}, 32'd0);
            repeat (3) step();
         end else begin
            run_layer(vecs[i].c1, vecs[i].w, vecs[i].ch, vecs[i].rows, vecs[i].mode);
         end
      end

      // Randomized legal layers
      for (int k = 0; k < 8; k++) begin
         run_layer($urandom_range(0, 1), $urandom_range(1, 5), 8 * $urandom_range(1, 4),
                   $urandom_range(1, 16), 2);
      end

      // Starvation: conv3, bank 2 becomes full 10 cycles after banks 0 and 1
      bus.ifm_bram_full = 12'h011;
      exp_q.push_back(12'h007);
      first_strobe_cyc = -1;
      done0 = done_cnt;
      set_cfg(0, 1, 1, 8, 1);
      bus.pe_ready = 1'b1;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (9) step();
      check("starve_no_early_strobe", first_strobe_cyc, 32'hffffffff);
      bus.ifm_bram_full = 12'h111;
      flag_cyc = cyc;
      n = 0;
      while (done_cnt == done0 && n < 20) begin
         step();
         n++;
      end
      check("starve_done_seen", done_cnt - done0, 1);
      check("starve_first_strobe", first_strobe_cyc - flag_cyc, 1);
`ifdef IFM_SCHED_PERF_EN
      check("starve_cnt_10", bus.starve_cnt, 10);
`endif
      bus.ifm_bram_full = '1;
      exp_q.delete();
      step();

      // Reset in the middle of READ, then a clean restart at bank 0
      for (int b = 0; b < 4; b++) exp_q.push_back(12'h001);
      set_cfg(1, 0, 4, 8, 1);
      bus.pe_ready = 1'b1;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      step();
      check("pre_rst_strobe", {20'd0, bus.dout_valid}, 32'h001);
      done0 = done_cnt;
      rst = 1'b1;
      #1;
      check("rst_mid_dout_valid", {20'd0, bus.dout_valid}, 32'd0);
      check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_mid_beat_valid", {31'd0, bus.pe_beat_valid}, 32'd0);
      check("rst_mid_done", {31'd0, bus.done}, 32'd0);
      step();
      rst = 1'b0;
      bus.pe_ready = 1'b0;
      exp_q.delete();
      repeat (5) step();
      check("rst_no_done", done_cnt - done0, 0);
      run_layer(1, 4, 8, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
